nor_gate: RTL and testbench

//   Parameterised bitwise 2-input NOR unit: y = ~(in_a | in_b) per lane.

---
 rtl/nor_gate_if.sv | 38 +++
 rtl/nor_gate.sv | 71 +++++++
 tb/tb_nor_gate.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nor_gate_if.sv
// Bundles the operand, qualifier and result signals of the NOR unit.
// The master side drives operands and controls. The slave side (the gate)
// drives the results.
interface nor_gate_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_valid;
    logic                 clr_cnt;
    logic [WIDTH-1:0]     y;
    logic [WIDTH-1:0]     y_q;
    logic                 y_q_valid;
    logic [CNT_WIDTH-1:0] fall_cnt;

    modport master (
        output in_a,
        output in_b,
        output in_valid,
        output clr_cnt,
        input  y,
        input  y_q,
        input  y_q_valid,
        input  fall_cnt
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  in_valid,
        input  clr_cnt,
        output y,
        output y_q,
        output y_q_valid,
        output fall_cnt
    );
endinterface

// File: rtl/nor_gate.sv
// Bitwise 2-input NOR unit with three outputs:
//   - a zero-latency combinational result,
//   - a registered copy that is qualified by a valid flag,
//   - a saturating counter of lane-0 falling edges on the registered copy.
// The combinational path is kept independent of clk and rst.
module nor_gate #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    nor_gate_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     w_y;
    logic [WIDTH-1:0]     w_y_q_next;
    logic                 w_y_q_valid_next;
    logic                 w_fall;
    logic [CNT_WIDTH-1:0] w_fall_cnt_next;

    logic [WIDTH-1:0]     r_y_q;
    logic                 r_y_q_valid;
    logic [CNT_WIDTH-1:0] r_fall_cnt;

    // Each lane is an independent NOR of its two operand bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_lane
            assign w_y[gi] = ~(bus.in_a[gi] | bus.in_b[gi]);
        end
    endgenerate

    // Next-state for the registered result, its valid flag and the edge counter.
    always_comb begin
        w_y_q_next       = r_y_q;
        w_y_q_valid_next = 1'b0;
        w_fall_cnt_next  = r_fall_cnt;
        if (bus.in_valid) begin
            w_y_q_next       = w_y;
            w_y_q_valid_next = 1'b1;
        end
        // A fall is lane 0 of the registered result going from 1 to 0 on this edge.
        w_fall = r_y_q[0] & ~w_y_q_next[0];
        // A clear takes precedence over an increment in the same cycle.
        if (bus.clr_cnt) begin
            w_fall_cnt_next = '0;
        end else if (w_fall && (r_fall_cnt != CNT_MAX)) begin
            w_fall_cnt_next = r_fall_cnt + CNT_ONE;
        end
    end

    // State registers. Reset loads the NOR of all-zero inputs, which is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q       <= '1;
            r_y_q_valid <= 1'b0;
            r_fall_cnt  <= '0;
        end else begin
            r_y_q       <= w_y_q_next;
            r_y_q_valid <= w_y_q_valid_next;
            r_fall_cnt  <= w_fall_cnt_next;
        end
    end

    assign bus.y         = w_y;
    assign bus.y_q       = r_y_q;
    assign bus.y_q_valid = r_y_q_valid;
    assign bus.fall_cnt  = r_fall_cnt;
endmodule

// File: tb/tb_nor_gate.sv
// Directed bench for nor_gate.
// Instance A is 4 lanes wide with a 16-bit counter.
// Instance B is 1 lane wide with a 2-bit counter, to exercise saturation.
module tb_nor_gate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   y_changes = 0;

    nor_gate_if #(.WIDTH(4), .CNT_WIDTH(16)) a_if ();
    nor_gate_if #(.WIDTH(1), .CNT_WIDTH(2))  b_if ();

    nor_gate #(.WIDTH(4), .CNT_WIDTH(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    nor_gate #(.WIDTH(1), .CNT_WIDTH(2))  dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    always #5 clk = ~clk;

    always @(a_if.y) y_changes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] a, input logic [3:0] b, input logic v);
        a_if.in_a = a;
        a_if.in_b = b;
        a_if.in_valid = v;
    endtask

    task automatic drive_b(input logic a, input logic v, input logic clr);
        b_if.in_a = a;
        b_if.in_b = 1'b0;
        b_if.in_valid = v;
        b_if.clr_cnt = clr;
    endtask

    initial begin
        drive_a(4'h0, 4'h0, 1'b0);
        a_if.clr_cnt = 1'b0;
        drive_b(1'b0, 1'b0, 1'b0);

        // 1: the combinational output is valid immediately, then the reset state.
        #1;
        chk("y_zero_inputs", 32'(a_if.y), 32'hF);
        @(negedge clk);
        chk("rst_y_q", 32'(a_if.y_q), 32'hF);
        chk("rst_y_q_valid", 32'(a_if.y_q_valid), 32'h0);
        chk("rst_fall_cnt", 32'(a_if.fall_cnt), 32'h0);
        chk("rst_b_y_q", 32'(b_if.y_q), 32'h1);
        rst = 1'b0;

        // 2: truth-table walk on the combinational path (registered path idle).
        drive_a(4'hF, 4'h0, 1'b0); #1; chk("y_10", 32'(a_if.y), 32'h0);
        drive_a(4'h0, 4'hF, 1'b0); #1; chk("y_01", 32'(a_if.y), 32'h0);
        drive_a(4'hF, 4'hF, 1'b0); #1; chk("y_11", 32'(a_if.y), 32'h0);
        drive_a(4'h0, 4'h0, 1'b0); #1; chk("y_00", 32'(a_if.y), 32'hF);
        @(negedge clk);
        drive_a(4'b1010, 4'b0100, 1'b0); #1; chk("y_mixed", 32'(a_if.y), 32'h1);
        // a falls and b rises in the same timestep: y must not change at all.
        drive_a(4'hF, 4'h0, 1'b0); #1;
        y_changes = 0;
        drive_a(4'h0, 4'hF, 1'b0); #1;
        chk("y_no_glitch_val", 32'(a_if.y), 32'h0);
        chk("y_no_glitch_evt", 32'(y_changes), 32'h0);

        // 3: a valid capture of lane0 a=1 gives y_q=E and counts one fall.
        @(negedge clk);
        drive_a(4'h1, 4'h0, 1'b1);
        @(negedge clk);
        chk("cap_y_q", 32'(a_if.y_q), 32'hE);
        chk("cap_valid", 32'(a_if.y_q_valid), 32'h1);
        chk("cap_fall_cnt", 32'(a_if.fall_cnt), 32'h1);

        // 4: with in_valid low for 3 cycles, y_q holds while the inputs toggle.
        drive_a(4'h0, 4'h0, 1'b0); @(negedge clk);
        chk("hold1_y_q", 32'(a_if.y_q), 32'hE);
        chk("hold1_valid", 32'(a_if.y_q_valid), 32'h0);
        drive_a(4'hF, 4'h3, 1'b0); @(negedge clk);
        chk("hold2_y_q", 32'(a_if.y_q), 32'hE);
        drive_a(4'h0, 4'h0, 1'b0); @(negedge clk);
        chk("hold3_y_q", 32'(a_if.y_q), 32'hE);
        chk("hold3_valid", 32'(a_if.y_q_valid), 32'h0);
        chk("hold3_fall_cnt", 32'(a_if.fall_cnt), 32'h1);

        // A fall on lane 1 only, and a repeated 0 on lane 0, must not count.
        drive_a(4'h0, 4'h0, 1'b1); @(negedge clk);
        chk("rise_y_q", 32'(a_if.y_q), 32'hF);
        drive_a(4'h2, 4'h0, 1'b1); @(negedge clk);
        chk("lane1_fall_y_q", 32'(a_if.y_q), 32'hD);
        chk("lane1_fall_cnt", 32'(a_if.fall_cnt), 32'h1);
        drive_a(4'h1, 4'h0, 1'b1); @(negedge clk);
        chk("fall2_cnt", 32'(a_if.fall_cnt), 32'h2);
        drive_a(4'h0, 4'h1, 1'b1); @(negedge clk);
        chk("stay0_cnt", 32'(a_if.fall_cnt), 32'h2);

        // Three more lane-0 falls bring the count to 5.
        for (int k = 0; k < 3; k++) begin
            drive_a(4'h0, 4'h0, 1'b1); @(negedge clk);
            drive_a(4'h1, 4'h0, 1'b1); @(negedge clk);
        end
        chk("pre_rst_cnt", 32'(a_if.fall_cnt), 32'h5);
        chk("pre_rst_y_q", 32'(a_if.y_q), 32'hE);

        // 5: reset wins over in_valid and clr_cnt.
        rst = 1'b1;
        drive_a(4'hF, 4'h0, 1'b1);
        a_if.clr_cnt = 1'b1;
        @(negedge clk);
        chk("rst2_y_q", 32'(a_if.y_q), 32'hF);
        chk("rst2_valid", 32'(a_if.y_q_valid), 32'h0);
        chk("rst2_cnt", 32'(a_if.fall_cnt), 32'h0);
        rst = 1'b0;
        a_if.clr_cnt = 1'b0;
        drive_a(4'h0, 4'h0, 1'b0); @(negedge clk);
        chk("post_rst_valid", 32'(a_if.y_q_valid), 32'h0);
        drive_a(4'h1, 4'h2, 1'b1); @(negedge clk);
        chk("post_rst_y_q", 32'(a_if.y_q), 32'hC);
        chk("post_rst_valid1", 32'(a_if.y_q_valid), 32'h1);
        chk("post_rst_cnt", 32'(a_if.fall_cnt), 32'h1);

        // clr_cnt on its own clears the count and leaves y_q alone.
        drive_a(4'h0, 4'h0, 1'b0);
        a_if.clr_cnt = 1'b1; @(negedge clk);
        a_if.clr_cnt = 1'b0;
        chk("clr_only_cnt", 32'(a_if.fall_cnt), 32'h0);
        chk("clr_only_y_q", 32'(a_if.y_q), 32'hC);

        // 6: with a 2-bit counter, four falls saturate the count at 3.
        for (int k = 0; k < 4; k++) begin
            drive_b(1'b0, 1'b1, 1'b0); @(negedge clk);
            drive_b(1'b1, 1'b1, 1'b0); @(negedge clk);
            chk($sformatf("sat_cnt_%0d", k), 32'(b_if.fall_cnt), (k < 3) ? k + 1 : 3);
        end
        drive_b(1'b0, 1'b1, 1'b0); @(negedge clk);
        chk("sat_hold_cnt", 32'(b_if.fall_cnt), 32'h3);
        // A clear in the same cycle as a fall leaves the count at 0.
        drive_b(1'b1, 1'b1, 1'b1); @(negedge clk);
        chk("clr_fall_cnt", 32'(b_if.fall_cnt), 32'h0);
        chk("clr_fall_y_q", 32'(b_if.y_q), 32'h0);
        drive_b(1'b0, 1'b0, 1'b0); @(negedge clk);
        chk("clr_after_cnt", 32'(b_if.fall_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
